// File: rtl/skinny_sbox8_isw1_np.sv
// First-order (2-share ISW) masked SKINNY-128 8-bit S-box.
// Four register stages, one MIX round each; the result appears 4 edges after the inputs settle.
module skinny_sbox8_isw1_np (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] si0,
  input  logic [7:0] si1,
  input  logic [7:0] r,
  output logic [7:0] so0,
  output logic [7:0] so1
);

  function automatic logic [7:0] perm(input logic [7:0] x);
    logic [7:0] y;
    y[2] = x[0];
    y[7] = x[2];
    y[6] = x[1];
    y[0] = x[5];
    y[1] = x[3];
    y[4] = x[6];
    y[5] = x[7];
    y[3] = x[4];
    return y;
  endfunction

  function automatic logic [7:0] swap12(input logic [7:0] x);
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  // The random bit is folded into the cross term before it meets the same-domain product.
  function automatic logic [1:0] isw_and(input logic a0, input logic a1,
                                         input logic b0, input logic b1,
                                         input logic q);
    logic cross0;
    logic cross1;
    cross0 = (a0 & b1) ^ q;
    cross1 = (a1 & b0) ^ q;
    return {(a1 & b1) ^ cross1, (a0 & b0) ^ cross0};
  endfunction

  logic [7:0] sh0_q [4];
  logic [7:0] sh1_q [4];
  logic [7:0] sh0_d [4];
  logic [7:0] sh1_d [4];

  for (genvar k = 0; k < 4; k++) begin : g_round
    logic [7:0] in0;
    logic [7:0] in1;
    logic [1:0] zHi;
    logic [1:0] zLo;

    if (k == 0) begin : g_first
      assign in0 = si0;
      assign in1 = si1;
    end else begin : g_next
      assign in0 = perm(sh0_q[k-1]);
      assign in1 = perm(sh1_q[k-1]);
    end

    // NOR = AND of complements; complementing share 0 alone complements the shared value.
    assign zHi = isw_and(~in0[7], in1[7], ~in0[6], in1[6], r[2*k]);
    assign zLo = isw_and(~in0[3], in1[3], ~in0[2], in1[2], r[2*k+1]);

    assign sh0_d[k] = {in0[7:5], in0[4] ^ zHi[0], in0[3:1], in0[0] ^ zLo[0]};
    assign sh1_d[k] = {in1[7:5], in1[4] ^ zHi[1], in1[3:1], in1[0] ^ zLo[1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        sh0_q[k] <= '0;
        sh1_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        sh0_q[k] <= sh0_d[k];
        sh1_q[k] <= sh1_d[k];
      end
    end
  end

  assign so0 = swap12(sh0_q[3]);
  assign so1 = swap12(sh1_q[3]);

endmodule

// File: tb/tb_skinny_sbox8_isw1_np.sv
// Directed and exhaustive checks of the masked SKINNY 8-bit S-box against hand values
// and an unmasked reference of the S-box round structure.
module tb_skinny_sbox8_isw1_np;

  logic       clk;
  logic       rst_n;
  logic [7:0] si0;
  logic [7:0] si1;
  logic [7:0] r;
  logic [7:0] so0;
  logic [7:0] so1;

  int vectorCount;
  int miscompares;

  skinny_sbox8_isw1_np dut (
    .clk  (clk),
    .rst_n(rst_n),
    .si0  (si0),
    .si1  (si1),
    .r    (r),
    .so0  (so0),
    .so1  (so1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unmasked S8 built straight from the MIX / PERM / SWAP round description.
  function automatic logic [7:0] refSbox(input logic [7:0] xin);
    logic [7:0] x;
    logic [7:0] y;
    x = xin;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        y[2] = x[0]; y[7] = x[2]; y[6] = x[1]; y[0] = x[5];
        y[1] = x[3]; y[4] = x[6]; y[5] = x[7]; y[3] = x[4];
        x = y;
      end
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
    end
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %02h, expected %02h", tag, observed, expected);
    end
  endtask

  // Drive on the falling edge, let four rising edges pass, sample on the next falling edge.
  task automatic applyStimulus(input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] rv);
    @(negedge clk);
    si0 = s0;
    si1 = s1;
    r   = rv;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] firstShare;
    logic       sharesVary;

    vectorCount = 0;
    miscompares = 0;
    rst_n = 1'b0;
    si0 = 8'h00;
    si1 = 8'h00;
    r   = 8'h00;

    repeat (2) @(negedge clk);
    checkOutput("reset_so0", so0, 8'h00);
    checkOutput("reset_so1", so1, 8'h00);
    rst_n = 1'b1;

    checkOutput("ref_s8_00", refSbox(8'h00), 8'h65);
    checkOutput("ref_s8_37", refSbox(8'h37), 8'ha9);

    applyStimulus(8'h00, 8'h00, 8'h00);
    checkOutput("zero_plain", so0 ^ so1, 8'h65);
    applyStimulus(8'h5a, 8'h5a, 8'ha5);
    checkOutput("zero_masked", so0 ^ so1, 8'h65);
    applyStimulus(8'hfe, 8'hff, 8'h3c);
    checkOutput("one_masked", so0 ^ so1, 8'h4c);
    applyStimulus(8'h0f, 8'hf0, 8'hff);
    checkOutput("all_ones", so0 ^ so1, 8'hff);

    // Reset in the middle of an evaluation clears the outputs at once.
    @(negedge clk);
    si0 = 8'h3c;
    si1 = 8'h81;
    r   = 8'h6e;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_so0", so0, 8'h00);
    checkOutput("midreset_so1", so1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h01, 8'h00, 8'h00);
    checkOutput("after_reset", so0 ^ so1, 8'h4c);

    sharesVary = 1'b0;
    firstShare = 8'h00;
    for (int i = 0; i < 16; i++) begin
      m = 8'(i * 8'h1d + 8'h07);
      applyStimulus(8'h37 ^ m, m, 8'(i * 8'h35 + 8'h0b));
      checkOutput($sformatf("indep_%0d", i), so0 ^ so1, 8'ha9);
      if (i == 0) firstShare = so0;
      else if (so0 !== firstShare) sharesVary = 1'b1;
    end
    checkOutput("shares_vary", {7'd0, sharesVary}, 8'h01);

    for (int v = 0; v < 256; v++) begin
      m = 8'($urandom_range(255));
      applyStimulus(8'(v) ^ m, m, 8'($urandom_range(255)));
      checkOutput($sformatf("exh_%02h", v), so0 ^ so1, refSbox(8'(v)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule

// File: doc/skinny_sbox8_isw1_np.md
Name: skinny_sbox8_isw1_np

Overview:
- First-order masked (2-share, ISW) implementation of the SKINNY-128 8-bit S-box, used by the masked SKINNY-128-384+ round datapath.
- Input is a Boolean-shared byte (si0 ^ si1); output is a Boolean-shared byte (so0 ^ so1) equal to S8(si0 ^ si1).
- Non-pipelined: the input shares must be held stable until the result emerges, 4 clock edges later.
- Unmasked reference function S8 is the standard SKINNY 8-bit S-box (S8[0x00]=0x65, S8[0x01]=0x4c, S8[0xff]=0xff).

Parameters:
- none

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- si0  in  8  input share 0.
- si1  in  8  input share 1.
- r  in  8  fresh randomness; bit 2k+j is used by ISW AND j of round k.
- so0  out  8  output share 0.
- so1  out  8  output share 1.

Behaviour:
- One clock, clk; reset rst_n is asynchronous, active-low.
- Unmasked round structure on x[7:0], with MIX, PERM and SWAP defined as follows:
  - MIX: x4 ^= NOR(x7,x6); x0 ^= NOR(x3,x2).
  - PERM: y2=x0, y7=x2, y6=x1, y0=x5, y1=x3, y4=x6, y5=x7, y3=x4.
  - SWAP: exchange bits 1 and 2.
- S8 = SWAP(MIX(PERM(MIX(PERM(MIX(PERM(MIX(x)))))))): 4 MIX rounds, 8 NOR gates in total.
- Masked NOR: NOR(a,b) = (~a)&(~b). Invert share 0 only of each operand, then apply ISW AND.
- ISW AND with shares (a0,a1),(b0,b1) and random bit q:
  - z0 = a0&b0 ^ (a0&b1 ^ q)
  - z1 = a1&b1 ^ (a1&b0 ^ q)
  - The cross term plus random bit is computed before it is combined with the same-domain product.
- Per-round randomness:
  - Round k (0..3): AND on bit 4 uses r[2k]; AND on bit 0 uses r[2k+1].
  - Each r bit is used exactly once per S-box evaluation.
- Linear operations (XOR, PERM, SWAP) are applied sharewise, with no cross-share mixing.
- Datapath: 4 register stages; stage k holds both 8-bit shares after MIX round k.
  - PERM between rounds is combinational wiring between stages.
  - Final SWAP is wiring on the stage-4 outputs.
  - Bypass: linear (non-NOR) bits pass through the same stage registers, so both shares stay aligned per round.
- Latency: so0 ^ so1 = S8(si0 ^ si1) after the 4th rising edge following the last change of si0, si1 and r.
  - All inputs must be held stable for those 4 edges.
  - Output is undefined while the pipeline is filling with changed inputs; it is not flagged.
- No handshake and no valid signal.
- Reset: all stage registers are cleared asynchronously to 0, so so0=so1=0 while rst_n=0.
  - On deassertion, operation resumes at the next edge; a reset mid-evaluation discards it.
- Correctness must hold for any mask value and any r value; output shares individually vary with the mask and r.
- Security: first-order probing secure.
  - No combinational path may combine both shares of the same variable without an intervening random bit and register.

Test Plan:
- Exhaustive check: for all si in 0..255, pick random mask m and random r; drive si0=si^m, si1=m; wait 4 rising edges; at the following negedge check so0^so1 against the 256-entry S8 table.
- Zero input with fixed values si0=0x00, si1=0x00, r=0x00 -> so0^so1=0x65 after 4 edges.
- Masked zero: si0=0x5a, si1=0x5a, r=0xa5 -> so0^so1=0x65; si0=0xfe, si1=0xff, r=0x3c -> 0x4c.
- All-ones: si0=0x0f, si1=0xf0, r=0xff -> so0^so1=0xff.
- Reset: assert rst_n=0 mid-evaluation -> so0=so1=0 immediately; release and hold si0=0x01, si1=0x00 for 4 edges -> 0x4c.
- Randomness independence: same si=0x37 repeated with 16 different (mask, r) pairs -> so0^so1 constant (S8[0x37]); individual shares vary.
